// File: rtl/l2_cache_pkg.sv
// Shared parameters, FSM state encoding and address split helpers for the L2 controller.
package l2_cache_pkg;
    localparam int TAG_W   = 8;
    localparam int INDEX_W = 4;
    localparam int DATA_W  = 8;
    localparam int WAYS    = 8;
    localparam int WAY_W   = 3;
    localparam int ADDR_W  = TAG_W + INDEX_W;
    localparam int SETS    = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT,
        RESPOND
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[INDEX_W-1:0];
    endfunction
endpackage

// File: rtl/l2_cache_controller_if.sv
// L1 request/response, memory request/response and statistics bundle for the L2 controller.
interface l2_cache_controller_if;
    import l2_cache_pkg::*;

    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddress;
    logic [DATA_W-1:0] reqData;
    logic              respValid;
    logic              respHit;
    logic [DATA_W-1:0] respData;
    logic              memReqValid;
    logic              memReqReady;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memRespValid;
    logic [DATA_W-1:0] memRespData;
    logic [15:0]       hitCount;
    logic [15:0]       missCount;

    modport master (
        output reqValid, reqWrite, reqAddress, reqData, memReqReady, memRespValid, memRespData,
        input  reqReady, respValid, respHit, respData, memReqValid, memWrite, memAddress,
               memWriteData, hitCount, missCount
    );

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqData, memReqReady, memRespValid, memRespData,
        output reqReady, respValid, respHit, respData, memReqValid, memWrite, memAddress,
               memWriteData, hitCount, missCount
    );
endinterface

// File: rtl/l2_cache_controller_way_match.sv
// Per-way tag compare for one set: hit vector, any-hit and lowest-index encoded hit way.
module way_match
    import l2_cache_pkg::*;
(
    input  logic [WAYS-1:0]            i_valid,
    input  logic [WAYS-1:0][TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]           i_tag,
    output logic [WAYS-1:0]            o_hitVec,
    output logic                       o_hit,
    output logic [WAY_W-1:0]           o_way
);
    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign o_hitVec[w] = i_valid[w] && (i_tags[w] == i_tag);
    end

    assign o_hit = |o_hitVec;

    always_comb begin
        o_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (o_hitVec[w]) o_way = WAY_W'(w);
        end
    end
endmodule

// File: rtl/l2_cache_controller.sv
// 8-way set-associative L2 sequencing controller: lookup, victim select, writeback, fill, respond.
module l2_cache_controller
    import l2_cache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    l2_cache_controller_if.slave   bus
);
    state_e r_state, w_next;

    logic [WAYS-1:0][TAG_W-1:0]  r_tag  [SETS];
    logic [WAYS-1:0][DATA_W-1:0] r_data [SETS];
    logic [WAYS-1:0]             r_valid [SETS];
    logic [WAYS-1:0]             r_dirty [SETS];
    logic [WAY_W-1:0]            r_ptr   [SETS];

    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  r_victim;
    logic              r_fromPtr;
    logic [ADDR_W-1:0] r_wbAddr;
    logic [DATA_W-1:0] r_wbData;
    logic              r_respHit;
    logic [DATA_W-1:0] r_respData;
    logic [15:0]       r_hitCount;
    logic [15:0]       r_missCount;

    logic [INDEX_W-1:0]          w_idx;
    logic [TAG_W-1:0]            w_tag;
    logic [WAYS-1:0]             w_setValid;
    logic [WAYS-1:0]             w_setDirty;
    logic [WAYS-1:0][TAG_W-1:0]  w_setTags;
    logic [WAYS-1:0][DATA_W-1:0] w_setData;
    logic [WAYS-1:0]             w_hitVec;
    logic                        w_hit;
    logic [WAY_W-1:0]            w_hitWay;
    logic                        w_freeFound;
    logic [WAY_W-1:0]            w_freeWay;
    logic [WAY_W-1:0]            w_victim;
    logic                        w_victimDirty;
    logic                        w_fillDone;

    assign w_idx      = addr_idx(r_addr);
    assign w_tag      = addr_tag(r_addr);
    assign w_setValid = r_valid[w_idx];
    assign w_setDirty = r_dirty[w_idx];
    assign w_setTags  = r_tag[w_idx];
    assign w_setData  = r_data[w_idx];
    assign w_fillDone = (r_state == FILL_WAIT) && bus.memRespValid;

    way_match u_way_match (
        .i_valid  (w_setValid),
        .i_tags   (w_setTags),
        .i_tag    (w_tag),
        .o_hitVec (w_hitVec),
        .o_hit    (w_hit),
        .o_way    (w_hitWay)
    );

    // Invalid ways are consumed lowest-first; only a full set falls back to round-robin.
    always_comb begin
        w_freeFound = 1'b0;
        w_freeWay   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_setValid[w]) begin
                w_freeFound = 1'b1;
                w_freeWay   = WAY_W'(w);
            end
        end
    end

    assign w_victim      = w_freeFound ? w_freeWay : r_ptr[w_idx];
    assign w_victimDirty = w_setValid[w_victim] && w_setDirty[w_victim];

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.reqValid) w_next = LOOKUP;
            LOOKUP:    w_next = w_hit ? RESPOND : (w_victimDirty ? WRITEBACK : FILL_REQ);
            WRITEBACK: if (bus.memReqReady) w_next = FILL_REQ;
            FILL_REQ:  if (bus.memReqReady) w_next = FILL_WAIT;
            FILL_WAIT: if (bus.memRespValid) w_next = RESPOND;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady     = (r_state == IDLE);
        bus.respValid    = (r_state == RESPOND);
        bus.respHit      = (r_state == RESPOND) && r_respHit;
        bus.respData     = (r_state == RESPOND) ? r_respData : '0;
        bus.memReqValid  = (r_state == WRITEBACK) || (r_state == FILL_REQ);
        bus.memWrite     = (r_state == WRITEBACK);
        bus.memAddress   = (r_state == WRITEBACK) ? r_wbAddr :
                           (r_state == FILL_REQ)  ? r_addr   : '0;
        bus.memWriteData = (r_state == WRITEBACK) ? r_wbData : '0;
        bus.hitCount     = r_hitCount;
        bus.missCount    = r_missCount;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_fromPtr   <= 1'b0;
            r_wbAddr    <= '0;
            r_wbData    <= '0;
            r_respHit   <= 1'b0;
            r_respData  <= '0;
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.reqValid) begin
                    r_write <= bus.reqWrite;
                    r_addr  <= bus.reqAddress;
                    r_wdata <= bus.reqData;
                end
                LOOKUP: if (w_hit) begin
                    r_respHit  <= 1'b1;
                    r_respData <= r_write ? r_wdata : w_setData[w_hitWay];
                    if (r_write) r_dirty[w_idx] <= w_setDirty | w_hitVec;
                    if (r_hitCount != 16'hFFFF) r_hitCount <= r_hitCount + 16'd1;
                end else begin
                    r_respHit <= 1'b0;
                    r_victim  <= w_victim;
                    r_fromPtr <= !w_freeFound;
                    r_wbAddr  <= {w_setTags[w_victim], w_idx};
                    r_wbData  <= w_setData[w_victim];
                    if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
                end
                FILL_WAIT: if (bus.memRespValid) begin
                    r_valid[w_idx][r_victim] <= 1'b1;
                    r_dirty[w_idx][r_victim] <= r_write;
                    r_respData <= r_write ? r_wdata : bus.memRespData;
                    if (r_fromPtr) r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage is not reset; the reset guard keeps a fill racing reset out of the arrays.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == LOOKUP && w_hit && r_write)
                r_data[w_idx][w_hitWay] <= r_wdata;
            if (w_fillDone) begin
                r_tag[w_idx][r_victim]  <= w_tag;
                r_data[w_idx][r_victim] <= r_write ? r_wdata : bus.memRespData;
            end
        end
    end
endmodule

// File: tb/tb_l2_cache_controller.sv
// Directed bench for l2_cache_controller with an auto-responding memory model in cpu_req.
module tb_l2_cache_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    l2_cache_controller_if bus ();

    l2_cache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One L1 transaction; memory accepts at once and returns fill data one cycle into FILL_WAIT.
    task automatic cpu_req(input logic wr, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] fill, output logic hit, output logic [7:0] rd,
                           output int lat, output logic wb, output logic [11:0] wba,
                           output logic [7:0] wbd, output logic [11:0] fa);
        int  n, dly;
        logic done;
        hit = 0; rd = 0; lat = 0; wb = 0; wba = 0; wbd = 0; fa = 0; dly = 0; done = 0;
        bus.memReqReady = 1'b1;
        @(negedge clock);
        bus.reqValid = 1'b1; bus.reqWrite = wr; bus.reqAddress = a; bus.reqData = d;
        n = 0;
        while (!bus.reqReady && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clock);
        #1 bus.reqValid = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++; lat++;
            bus.memRespValid = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin bus.memRespValid = 1'b1; bus.memRespData = fill; end
            end
            if (bus.respValid) begin
                hit = bus.respHit; rd = bus.respData; done = 1;
            end else if (bus.memReqValid && bus.memWrite) begin
                wb = 1; wba = bus.memAddress; wbd = bus.memWriteData;
            end else if (bus.memReqValid && !bus.memWrite) begin
                fa = bus.memAddress; dly = 2;
            end
        end
        if (!done) chk("resp_timeout", 0, 1);
    endtask

    logic        hit, wb;
    logic [7:0]  rd, wbd;
    logic [11:0] wba, fa;
    int          lat;

    initial begin
        bus.reqValid = 0; bus.reqWrite = 0; bus.reqAddress = 0; bus.reqData = 0;
        bus.memReqReady = 1; bus.memRespValid = 0; bus.memRespData = 0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        chk("rst_reqReady", bus.reqReady, 1);
        chk("rst_respValid", bus.respValid, 0);
        chk("rst_memReqValid", bus.memReqValid, 0);
        chk("rst_hitCount", bus.hitCount, 0);
        chk("rst_missCount", bus.missCount, 0);

        // Cold read miss, then hit.
        cpu_req(0, 12'h123, 8'h00, 8'h5A, hit, rd, lat, wb, wba, wbd, fa);
        chk("cold_fa", fa, 12'h123);
        chk("cold_hit", hit, 0);
        chk("cold_data", rd, 8'h5A);
        chk("cold_lat", lat, 5);
        chk("cold_wb", wb, 0);
        chk("cold_miss", bus.missCount, 1);
        cpu_req(0, 12'h123, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("rehit_hit", hit, 1);
        chk("rehit_data", rd, 8'h5A);
        chk("rehit_lat", lat, 2);
        chk("rehit_count", bus.hitCount, 1);

        // Write hit dirties way 0; the 8th new tag in set 3 must write it back first.
        cpu_req(1, 12'h123, 8'h3C, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("wrhit_hit", hit, 1);
        chk("wrhit_data", rd, 8'h3C);
        for (int t = 0; t < 7; t++) begin
            cpu_req(0, {8'h20 + 8'(t), 4'h3}, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
            chk("set3_fill_wb", wb, 0);
        end
        cpu_req(0, 12'h273, 8'h00, 8'hC4, hit, rd, lat, wb, wba, wbd, fa);
        chk("evict_wb", wb, 1);
        chk("evict_wba", wba, 12'h123);
        chk("evict_wbd", wbd, 8'h3C);
        chk("evict_fa", fa, 12'h273);
        chk("evict_lat", lat, 6);
        chk("evict_data", rd, 8'hC4);

        // Nine clean tags into set 0: ninth takes way 0, pointer moves to 1.
        for (int t = 0; t < 9; t++) begin
            cpu_req(0, {8'h40 + 8'(t), 4'h0}, 8'h00, 8'(t), hit, rd, lat, wb, wba, wbd, fa);
            chk("set0_hit", hit, 0);
            chk("set0_wb", wb, 0);
        end
        cpu_req(0, 12'h410, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("set0_way1_hit", hit, 1);
        chk("set0_way1_data", rd, 8'h01);
        cpu_req(0, 12'h400, 8'h00, 8'hAB, hit, rd, lat, wb, wba, wbd, fa);
        chk("set0_way0_gone", hit, 0);
        cpu_req(0, 12'h420, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("set0_way2_hit", hit, 1);
        cpu_req(0, 12'h410, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("set0_way1_evicted", hit, 0);
        chk("counts_miss", bus.missCount, 20);
        chk("counts_hit", bus.hitCount, 4);

        // Memory stalls the fill request for 5 cycles; extra reqValid pulses are not taken.
        bus.memReqReady = 1'b0;
        @(negedge clock);
        bus.reqValid = 1; bus.reqWrite = 0; bus.reqAddress = 12'h5B1;
        @(posedge clock);
        #1 bus.reqValid = 0;
        begin
            int n = 0;
            while (!bus.memReqValid && n < 20) begin @(negedge clock); n++; end
            if (n >= 20) chk("stall_timeout", 0, 1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            bus.reqValid = c[0]; bus.reqAddress = 12'h777;
            chk("stall_valid", bus.memReqValid, 1);
            chk("stall_addr", bus.memAddress, 12'h5B1);
            chk("stall_write", bus.memWrite, 0);
            chk("stall_ready", bus.reqReady, 0);
        end
        bus.reqValid = 0; bus.memReqReady = 1;
        @(negedge clock);
        bus.memRespValid = 1; bus.memRespData = 8'h77;
        @(negedge clock);
        bus.memRespValid = 0;
        chk("stall_resp", bus.respValid, 1);
        chk("stall_data", bus.respData, 8'h77);
        chk("stall_hit", bus.respHit, 0);
        repeat (4) @(negedge clock);
        chk("stall_no_extra", bus.missCount + bus.hitCount, 25);

        // Reset lands while waiting for fill data; the late fill beat must be dropped.
        @(negedge clock);
        bus.reqValid = 1; bus.reqWrite = 0; bus.reqAddress = 12'h6C2;
        @(posedge clock);
        #1 bus.reqValid = 0;
        begin
            int n = 0;
            while (!bus.memReqValid && n < 20) begin @(negedge clock); n++; end
            if (n >= 20) chk("rstfw_timeout", 0, 1);
        end
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rstfw_ready", bus.reqReady, 1);
        chk("rstfw_memReqValid", bus.memReqValid, 0);
        bus.memRespValid = 1; bus.memRespData = 8'h99;
        @(negedge clock);
        bus.memRespValid = 0;
        chk("rstfw_respValid", bus.respValid, 0);
        chk("rstfw_ready2", bus.reqReady, 1);
        chk("rstfw_miss", bus.missCount, 0);
        chk("rstfw_hit", bus.hitCount, 0);
        cpu_req(0, 12'h6C2, 8'h00, 8'h42, hit, rd, lat, wb, wba, wbd, fa);
        chk("rstfw_refill_hit", hit, 0);
        chk("rstfw_refill_data", rd, 8'h42);

        // Write miss allocates a dirty line holding the write data.
        cpu_req(1, 12'h0A7, 8'h11, 8'hEE, hit, rd, lat, wb, wba, wbd, fa);
        chk("wmiss_fa", fa, 12'h0A7);
        chk("wmiss_hit", hit, 0);
        chk("wmiss_data", rd, 8'h11);
        chk("wmiss_lat", lat, 5);
        cpu_req(0, 12'h0A7, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("wmiss_read_hit", hit, 1);
        chk("wmiss_read_data", rd, 8'h11);
        for (int t = 0; t < 7; t++)
            cpu_req(0, {8'h80 + 8'(t), 4'h7}, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        cpu_req(0, 12'h877, 8'h00, 8'h00, hit, rd, lat, wb, wba, wbd, fa);
        chk("wmiss_dirty_wb", wb, 1);
        chk("wmiss_wba", wba, 12'h0A7);
        chk("wmiss_wbd", wbd, 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
